my_mod: RTL and testbench

- Small registered 9-bit datapath unit, instantiated as leaf `mymod`-style cells inside parse-level test tops.
- Each enabled cycle it combines input word `foo` with an internal accumulator using one of four operations.
- It publishes the accumulator plus reduction flags and a one-cycle change pulse.
- Two integer parameters set the shift amounts.

---
 rtl/my_mod_pkg.sv | 8 +
 rtl/my_mod_alu.sv | 21 ++
 rtl/my_mod.sv | 41 ++++
 tb/tb_my_mod.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/my_mod_pkg.sv
// my_mod_pkg: shared width and op encodings for the my_mod datapath.
package my_mod_pkg;
    localparam int WIDTH = 9;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SHL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;
endpackage

// File: rtl/my_mod_alu.sv
// my_mod_alu: combinational next-value for the accumulator.
module my_mod_alu
    import my_mod_pkg::*;
#(
    parameter int X = 1,
    parameter int Y = 2
) (
    input  logic [WIDTH-1:0] foo,
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] nxt
);
    // Kept separate so the ternary below cannot strip the signedness of the shift.
    logic signed [WIDTH-1:0] sra;
    assign sra = $signed(foo) >>> Y;
    always_comb begin
        nxt = op == OP_ADD ? acc + foo :
              op == OP_SHL ? foo << X :
              op == OP_SRA ? sra : acc ^ foo;
    end
endmodule

// File: rtl/my_mod.sv
// my_mod: registered 9-bit accumulator with reduction flags and change pulse.
module my_mod
    import my_mod_pkg::*;
#(
    parameter int X = 1,
    parameter int Y = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] foo,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic             clr,
    output logic [WIDTH-1:0] acc,
    output logic             par,
    output logic             any,
    output logic             all,
    output logic             chg
);
    logic [WIDTH-1:0] acc_q, acc_d, nxt;
    logic             chg_q, chg_d;
    my_mod_alu #(.X(X), .Y(Y)) u_alu (.foo(foo), .acc(acc_q), .op(op), .nxt(nxt));
    always_comb begin
        acc_d = clr ? '0 : en ? nxt : acc_q;
        chg_d = acc_d != acc_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            chg_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            chg_q <= chg_d;
        end
    end
    assign acc = acc_q;
    assign chg = chg_q;
    assign par = ^acc_q;
    assign any = |acc_q;
    assign all = &acc_q;
endmodule

// File: tb/tb_my_mod.sv
// tb_my_mod: directed self-checking bench for my_mod (X=1,Y=2 and X=3,Y=0).
module tb_my_mod;
    logic       clk = 1'b0;
    logic       rst_n, en, clr;
    logic [1:0] op;
    logic [8:0] foo;
    logic [8:0] acc, acc3;
    logic       par, any, all, chg, par3, any3, all3, chg3;
    int         total = 0;
    int         bad = 0;

    my_mod #(.X(1), .Y(2)) dut (
        .clk(clk), .rst_n(rst_n), .foo(foo), .en(en), .op(op), .clr(clr),
        .acc(acc), .par(par), .any(any), .all(all), .chg(chg)
    );
    my_mod #(.X(3), .Y(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .foo(foo), .en(en), .op(op), .clr(clr),
        .acc(acc3), .par(par3), .any(any3), .all(all3), .chg(chg3)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic e, input logic [1:0] o, input logic [8:0] f, input logic c);
        en = e; op = o; foo = f; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 2'b00, 9'd5, 0);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({acc, chg, par, any, all} !== 13'd0) begin
            $display("FAIL reset_async acc=%h chg=%b par=%b any=%b all=%b exp all 0", acc, chg, par, any, all);
            bad++;
        end
        total++;
        if (acc3 !== 9'd0) begin $display("FAIL reset_async3 acc=%h exp=000", acc3); bad++; end
        #2 rst_n = 1'b1;
        cyc(0, 2'b00, 9'd7, 0);
        total++;
        if (acc !== 9'd0 || chg !== 1'b0) begin
            $display("FAIL reset_release acc=%h chg=%b exp acc=000 chg=0", acc, chg);
            bad++;
        end
    endtask

    task automatic test_add_wrap;
        cyc(1, 2'b00, 9'd510, 0);
        total++;
        if (acc !== 9'd510 || chg !== 1'b1) begin
            $display("FAIL add_preload acc=%0d chg=%b exp acc=510 chg=1", acc, chg);
            bad++;
        end
        cyc(1, 2'b00, 9'd3, 0);
        total++;
        if (acc !== 9'd1 || chg !== 1'b1) begin
            $display("FAIL add_wrap acc=%0d chg=%b exp acc=1 chg=1", acc, chg);
            bad++;
        end
        cyc(0, 2'b00, 9'd3, 0);
        total++;
        if (acc !== 9'd1 || chg !== 1'b0) begin
            $display("FAIL add_hold acc=%0d chg=%b exp acc=1 chg=0", acc, chg);
            bad++;
        end
    endtask

    task automatic test_shifts;
        cyc(1, 2'b01, 9'h101, 0);
        total++;
        if (acc !== 9'h002) begin $display("FAIL shl_x1 acc=%h exp=002", acc); bad++; end
        total++;
        if (acc3 !== 9'h008) begin $display("FAIL shl_x3_trunc acc=%h exp=008", acc3); bad++; end
        cyc(1, 2'b10, 9'h180, 0);
        total++;
        if (acc !== 9'h1E0) begin $display("FAIL sra_y2 acc=%h exp=1e0", acc); bad++; end
        total++;
        if (acc3 !== 9'h180) begin $display("FAIL sra_y0 acc=%h exp=180", acc3); bad++; end
        cyc(1, 2'b10, 9'h0F0, 0);
        total++;
        if (acc !== 9'h03C) begin $display("FAIL sra_pos acc=%h exp=03c", acc); bad++; end
        cyc(1, 2'b01, 9'h001, 0);
        total++;
        if (acc !== 9'h002) begin $display("FAIL shl_one acc=%h exp=002", acc); bad++; end
        total++;
        if (acc3 !== 9'h008) begin $display("FAIL shl_x3 acc=%h exp=008", acc3); bad++; end
    endtask

    task automatic test_xor_flags;
        cyc(0, 2'b00, 9'h000, 1);
        cyc(1, 2'b00, 9'h0F0, 0);
        total++;
        if (acc !== 9'h0F0 || par !== 1'b0 || any !== 1'b1 || all !== 1'b0) begin
            $display("FAIL flags_0f0 acc=%h par=%b any=%b all=%b exp acc=0f0 par=0 any=1 all=0", acc, par, any, all);
            bad++;
        end
        cyc(1, 2'b11, 9'h10F, 0);
        total++;
        if (acc !== 9'h1FF || all !== 1'b1 || any !== 1'b1 || par !== 1'b1) begin
            $display("FAIL xor_ones acc=%h all=%b any=%b par=%b exp acc=1ff 1 1 1", acc, all, any, par);
            bad++;
        end
        cyc(1, 2'b11, 9'h1FF, 0);
        total++;
        if (acc !== 9'h000 || any !== 1'b0 || all !== 1'b0 || par !== 1'b0 || chg !== 1'b1) begin
            $display("FAIL xor_zero acc=%h any=%b all=%b par=%b chg=%b exp acc=000 0 0 0 chg=1", acc, any, all, par, chg);
            bad++;
        end
    endtask

    task automatic test_priority;
        cyc(1, 2'b00, 9'd7, 0);
        cyc(1, 2'b00, 9'd5, 1);
        total++;
        if (acc !== 9'd0 || chg !== 1'b1) begin
            $display("FAIL clr_over_en acc=%0d chg=%b exp acc=0 chg=1", acc, chg);
            bad++;
        end
        cyc(1, 2'b00, 9'd5, 1);
        total++;
        if (acc !== 9'd0 || chg !== 1'b0) begin
            $display("FAIL clr_again acc=%0d chg=%b exp acc=0 chg=0", acc, chg);
            bad++;
        end
        cyc(1, 2'b00, 9'd9, 0);
        cyc(0, 2'b00, 9'd9, 1);
        total++;
        if (acc !== 9'd0 || chg !== 1'b1) begin
            $display("FAIL clr_no_en acc=%0d chg=%b exp acc=0 chg=1", acc, chg);
            bad++;
        end
    endtask

    task automatic test_no_change;
        cyc(1, 2'b00, 9'h055, 0);
        cyc(1, 2'b11, 9'h000, 0);
        total++;
        if (acc !== 9'h055 || chg !== 1'b0 || par !== 1'b0) begin
            $display("FAIL xor_zero_nochg acc=%h chg=%b par=%b exp acc=055 chg=0 par=0", acc, chg, par);
            bad++;
        end
        cyc(1, 2'b00, 9'h000, 0);
        total++;
        if (acc !== 9'h055 || chg !== 1'b0) begin
            $display("FAIL add_zero_nochg acc=%h chg=%b exp acc=055 chg=0", acc, chg);
            bad++;
        end
    endtask

    task automatic test_back_to_back;
        cyc(0, 2'b00, 9'h000, 1);
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 2'b00, 9'd1, 0);
            total++;
            if (acc !== 9'(i) || chg !== 1'b1) begin
                $display("FAIL b2b_%0d acc=%0d chg=%b exp acc=%0d chg=1", i, acc, chg, i);
                bad++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; op = 2'b00; foo = 9'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (acc !== 9'd0 || chg !== 1'b0) begin
            $display("FAIL reset_hold acc=%h chg=%b exp acc=000 chg=0", acc, chg);
            bad++;
        end
        rst_n = 1'b1;
        test_reset;
        test_add_wrap;
        test_shifts;
        test_xor_flags;
        test_priority;
        test_no_change;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
